// File: rtl/mem_req_pkg.sv
// Shared types for the MEM-stage data request side.
// Store-type bit positions, bus size codes and FSM states.
package mem_req_pkg;

  localparam int ST_SB  = 0;
  localparam int ST_SH  = 1;
  localparam int ST_SW  = 2;
  localparam int ST_SWL = 3;
  localparam int ST_SWR = 4;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3,
    S_DISCARD = 3'd4
  } state_e;

endpackage

// File: rtl/mem_req_store_align.sv
// Store lane alignment: byte strobes, lane-placed data, size,
// and low address bits (SWL/SWR always address the full word).
module mem_req_store_align
  import mem_req_pkg::*;
(
  input  logic [4:0]  store_type_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [1:0]  size_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [1:0]  addr_lo_o
);

  always_comb begin
    size_o    = SZ_W;
    wstrb_o   = 4'b0000;
    wdata_o   = data_i;
    addr_lo_o = off_i;
    unique case (1'b1)
      store_type_i[ST_SB]: begin
        size_o  = SZ_B;
        wdata_o = {4{data_i[7:0]}};
        wstrb_o = 4'b0001 << off_i;
      end
      store_type_i[ST_SH]: begin
        size_o  = SZ_H;
        wdata_o = {2{data_i[15:0]}};
        wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
      end
      store_type_i[ST_SW]: begin
        wstrb_o = 4'b1111;
      end
      store_type_i[ST_SWL]: begin
        addr_lo_o = 2'b00;
        unique case (off_i)
          2'd0: begin
            wstrb_o = 4'b0001;
            wdata_o = data_i >> 24;
          end
          2'd1: begin
            wstrb_o = 4'b0011;
            wdata_o = data_i >> 16;
          end
          2'd2: begin
            wstrb_o = 4'b0111;
            wdata_o = data_i >> 8;
          end
          default: begin
            wstrb_o = 4'b1111;
            wdata_o = data_i;
          end
        endcase
      end
      store_type_i[ST_SWR]: begin
        addr_lo_o = 2'b00;
        unique case (off_i)
          2'd0: begin
            wstrb_o = 4'b1111;
            wdata_o = data_i;
          end
          2'd1: begin
            wstrb_o = 4'b1110;
            wdata_o = data_i << 8;
          end
          2'd2: begin
            wstrb_o = 4'b1100;
            wdata_o = data_i << 16;
          end
          default: begin
            wstrb_o = 4'b1000;
            wdata_o = data_i << 24;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_req.sv
// MEM-stage data request: one SRAM-like transaction per load/store,
// returning {offset, raw rdata} for downstream load extraction.
module mem_req
  import mem_req_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  output logic              allow_in,
  output logic              valid_out,
  input  logic              allow_out,
  input  logic [5:0]        ex,
  input  logic              flush,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [4:0]        store_type,
  input  logic [1:0]        load_size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic [1:0]        offset_out,
  output logic [DATA_W-1:0] data_out
);

  state_e state_q, state_d;

  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        off_q;
  logic              load_q;
  logic [DATA_W-1:0] data_q;

  logic [1:0]        al_size;
  logic [3:0]        al_wstrb;
  logic [DATA_W-1:0] al_wdata;
  logic [1:0]        al_lo;

  logic accept;
  logic go_mem;
  logic take_rdata;

  mem_req_store_align u_align (
    .store_type_i (store_type),
    .off_i        (addr[1:0]),
    .data_i       (store_data),
    .size_o       (al_size),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .addr_lo_o    (al_lo)
  );

  assign allow_in = (state_q == S_IDLE) ||
                    (state_q == S_DONE && allow_out);

  // A flush in DONE kills the slot, so nothing is taken that cycle.
  assign accept = valid && allow_in &&
                  !(state_q == S_DONE && flush);

  assign go_mem = (mem_re || mem_we) && (ex == 6'd0) && !flush;

  assign take_rdata = (state_q == S_WAIT) &&
                      data_sram_data_ok && !flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = go_mem ? S_REQ : S_DONE;
      end
      S_REQ: begin
        if (data_sram_addr_ok)
          state_d = flush ? S_DISCARD : S_WAIT;
        else if (flush)
          state_d = S_IDLE;
      end
      S_WAIT: begin
        if (data_sram_data_ok)
          state_d = flush ? S_IDLE : S_DONE;
        else if (flush)
          state_d = S_DISCARD;
      end
      S_DONE: begin
        if (flush)
          state_d = S_IDLE;
        else if (allow_out)
          state_d = accept ? (go_mem ? S_REQ : S_DONE) : S_IDLE;
      end
      S_DISCARD: begin
        if (data_sram_data_ok)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= '0;
      off_q   <= 2'd0;
      load_q  <= 1'b0;
      data_q  <= '0;
    end else if (accept) begin
      wr_q    <= mem_we;
      size_q  <= mem_we ? al_size : load_size;
      addr_q  <= mem_we ? {addr[ADDR_W-1:2], al_lo} : addr;
      wstrb_q <= mem_we ? al_wstrb : 4'b0000;
      wdata_q <= mem_we ? al_wdata : '0;
      off_q   <= addr[1:0];
      load_q  <= mem_re;
      data_q  <= '0;
    end else if (take_rdata) begin
      data_q  <= load_q ? data_sram_rdata : '0;
    end
  end

  assign data_sram_req   = (state_q == S_REQ);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;

  assign valid_out  = (state_q == S_DONE);
  assign offset_out = off_q;
  assign data_out   = data_q;

endmodule

// File: tb/tb_mem_req.sv
// Directed vector table plus hand sequences for mem_req.
module tb_mem_req;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid, allow_in, valid_out, allow_out;
  logic [5:0]  ex;
  logic        flush, mem_re, mem_we;
  logic [4:0]  store_type;
  logic [1:0]  load_size;
  logic [31:0] addr, store_data;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [1:0]  offset_out;
  logic [31:0] data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_req dut (
    .clk               (clk),
    .resetn            (resetn),
    .valid             (valid),
    .allow_in          (allow_in),
    .valid_out         (valid_out),
    .allow_out         (allow_out),
    .ex                (ex),
    .flush             (flush),
    .mem_re            (mem_re),
    .mem_we            (mem_we),
    .store_type        (store_type),
    .load_size         (load_size),
    .addr              (addr),
    .store_data        (store_data),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .offset_out        (offset_out),
    .data_out          (data_out)
  );

  typedef struct {
    logic        re;
    logic        we;
    logic [4:0]  st;
    logic [1:0]  lsz;
    logic [31:0] a;
    logic [31:0] d;
    logic [5:0]  ex;
    logic [31:0] rdata;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] baddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        cw;
    logic [31:0] dout;
    logic [1:0]  off;
  } vec_t;

  localparam int N = 19;
  vec_t v[N];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t x);
    mem_re     = x.re;
    mem_we     = x.we;
    store_type = x.st;
    load_size  = x.lsz;
    addr       = x.a;
    store_data = x.d;
    ex         = x.ex;
  endtask

  task automatic run_vec(input vec_t x, input int i);
    @(negedge clk);
    chk($sformatf("v%0d_allow_in", i), 32'(allow_in), 32'd1);
    set_in(x);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk($sformatf("v%0d_req", i), 32'(data_sram_req), 32'(x.req));
    if (x.req) begin
      chk($sformatf("v%0d_wr", i), 32'(data_sram_wr), 32'(x.wr));
      chk($sformatf("v%0d_size", i), 32'(data_sram_size), 32'(x.size));
      chk($sformatf("v%0d_addr", i), data_sram_addr, x.baddr);
      chk($sformatf("v%0d_wstrb", i), 32'(data_sram_wstrb), 32'(x.wstrb));
      if (x.cw)
        chk($sformatf("v%0d_wdata", i), data_sram_wdata, x.wdata);
      data_sram_addr_ok = 1'b1;
      @(negedge clk);
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = x.rdata;
      @(negedge clk);
      data_sram_data_ok = 1'b0;
    end
    chk($sformatf("v%0d_valid_out", i), 32'(valid_out), 32'd1);
    chk($sformatf("v%0d_data_out", i), data_out, x.dout);
    chk($sformatf("v%0d_offset", i), 32'(offset_out), 32'(x.off));
    allow_out = 1'b1;
    @(negedge clk);
    allow_out = 1'b0;
    chk($sformatf("v%0d_idle", i), 32'(valid_out), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int rq;
    // re we st lsz a d ex rdata | req wr size baddr wstrb wdata cw dout off
    v[0]  = '{0,1,5'b00001,0,32'h1003,32'h123456AB,0,32'hFFFFFFFF,
              1,1,0,32'h1003,4'b1000,32'hABABABAB,1,0,3};
    v[1]  = '{1,0,5'b00000,2,32'h2000,32'h0,0,32'hDEADBEEF,
              1,0,2,32'h2000,4'b0000,32'h0,0,32'hDEADBEEF,0};
    v[2]  = '{0,1,5'b01000,0,32'h3001,32'hAABBCCDD,0,32'h77777777,
              1,1,2,32'h3000,4'b0011,32'h0000AABB,1,0,1};
    v[3]  = '{0,1,5'b10000,0,32'h3002,32'hAABBCCDD,0,32'h77777777,
              1,1,2,32'h3000,4'b1100,32'hCCDD0000,1,0,2};
    v[4]  = '{0,1,5'b01000,0,32'h3000,32'hAABBCCDD,0,32'h0,
              1,1,2,32'h3000,4'b0001,32'h000000AA,1,0,0};
    v[5]  = '{0,1,5'b01000,0,32'h3002,32'hAABBCCDD,0,32'h0,
              1,1,2,32'h3000,4'b0111,32'h00AABBCC,1,0,2};
    v[6]  = '{0,1,5'b01000,0,32'h3003,32'hAABBCCDD,0,32'h0,
              1,1,2,32'h3000,4'b1111,32'hAABBCCDD,1,0,3};
    v[7]  = '{0,1,5'b10000,0,32'h3000,32'hAABBCCDD,0,32'h0,
              1,1,2,32'h3000,4'b1111,32'hAABBCCDD,1,0,0};
    v[8]  = '{0,1,5'b10000,0,32'h3001,32'hAABBCCDD,0,32'h0,
              1,1,2,32'h3000,4'b1110,32'hBBCCDD00,1,0,1};
    v[9]  = '{0,1,5'b10000,0,32'h3003,32'hAABBCCDD,0,32'h0,
              1,1,2,32'h3000,4'b1000,32'hDD000000,1,0,3};
    v[10] = '{0,1,5'b00100,0,32'h5000,32'hCAFEF00D,0,32'h12121212,
              1,1,2,32'h5000,4'b1111,32'hCAFEF00D,1,0,0};
    v[11] = '{0,1,5'b00010,0,32'h4002,32'h11223344,0,32'h0,
              1,1,1,32'h4002,4'b1100,32'h33443344,1,0,2};
    v[12] = '{0,1,5'b00010,0,32'h4000,32'h11223344,0,32'h0,
              1,1,1,32'h4000,4'b0011,32'h33443344,1,0,0};
    v[13] = '{0,1,5'b00001,0,32'h4001,32'h000000C3,0,32'h0,
              1,1,0,32'h4001,4'b0010,32'hC3C3C3C3,1,0,1};
    v[14] = '{1,0,5'b00000,0,32'h6001,32'h0,0,32'h11223344,
              1,0,0,32'h6001,4'b0000,32'h0,0,32'h11223344,1};
    v[15] = '{1,0,5'b00000,1,32'h6002,32'h0,0,32'h55667788,
              1,0,1,32'h6002,4'b0000,32'h0,0,32'h55667788,2};
    v[16] = '{1,0,5'b00000,2,32'h7002,32'h0,6'h04,32'hFFFFFFFF,
              0,0,0,32'h0,4'b0000,32'h0,0,32'h0,2};
    v[17] = '{0,0,5'b00000,0,32'h8001,32'h0,0,32'h0,
              0,0,0,32'h0,4'b0000,32'h0,0,32'h0,1};
    v[18] = '{0,1,5'b00100,0,32'h5001,32'h99,6'h05,32'h0,
              0,0,0,32'h0,4'b0000,32'h0,0,32'h0,1};

    resetn = 1'b0;
    valid = 0; allow_out = 0; ex = 0; flush = 0;
    mem_re = 0; mem_we = 0; store_type = 0; load_size = 0;
    addr = 0; store_data = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
    data_sram_rdata = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_allow_in", 32'(allow_in), 32'd1);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_req", 32'(data_sram_req), 32'd0);
    chk("rst_wstrb", 32'(data_sram_wstrb), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_offset", 32'(offset_out), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < N; i++) run_vec(v[i], i);

    // SB with addr_ok after 2 cycles, data_ok after 1
    @(negedge clk);
    set_in(v[0]);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    rq = 0;
    for (int k = 0; k < 3; k++) begin
      if (data_sram_req) rq++;
      chk($sformatf("sb_wstrb_%0d", k), 32'(data_sram_wstrb), 32'h8);
      chk($sformatf("sb_vo_%0d", k), 32'(valid_out), 32'd0);
      data_sram_addr_ok = (k == 2);
      @(negedge clk);
    end
    data_sram_addr_ok = 1'b0;
    chk("sb_req_cycles", 32'(rq), 32'd3);
    chk("sb_req_drop", 32'(data_sram_req), 32'd0);
    @(negedge clk);
    chk("sb_wait_vo", 32'(valid_out), 32'd0);
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    chk("sb_done_vo", 32'(valid_out), 32'd1);
    chk("sb_done_data", data_out, 32'd0);
    allow_out = 1'b1;
    @(negedge clk);
    allow_out = 1'b0;

    // flush while waiting for data_ok
    set_in(v[1]);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_in(v[17]);
    valid = 1'b1;
    chk("dis_allow_in_a", 32'(allow_in), 32'd0);
    chk("dis_vo_a", 32'(valid_out), 32'd0);
    @(negedge clk);
    chk("dis_allow_in_b", 32'(allow_in), 32'd0);
    chk("dis_vo_b", 32'(valid_out), 32'd0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h12345678;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    chk("dis_idle_allow", 32'(allow_in), 32'd1);
    chk("dis_idle_vo", 32'(valid_out), 32'd0);
    chk("dis_dropped", data_out, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    chk("dis_next_vo", 32'(valid_out), 32'd1);
    chk("dis_next_data", data_out, 32'd0);
    allow_out = 1'b1;
    @(negedge clk);
    allow_out = 1'b0;

    // flush in REQ before addr_ok
    set_in(v[10]);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("fr_req", 32'(data_sram_req), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fr_req_drop", 32'(data_sram_req), 32'd0);
    chk("fr_allow_in", 32'(allow_in), 32'd1);
    chk("fr_vo", 32'(valid_out), 32'd0);
    @(negedge clk);
    chk("fr_req_stay", 32'(data_sram_req), 32'd0);
    chk("fr_vo_stay", 32'(valid_out), 32'd0);

    // back-to-back: store accepted straight out of DONE
    set_in(v[17]);
    valid = 1'b1;
    @(negedge clk);
    chk("bb_vo", 32'(valid_out), 32'd1);
    set_in(v[10]);
    addr = 32'h5004;
    store_data = 32'h01020304;
    allow_out = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    allow_out = 1'b0;
    chk("bb_req", 32'(data_sram_req), 32'd1);
    chk("bb_addr", data_sram_addr, 32'h5004);
    chk("bb_wdata", data_sram_wdata, 32'h01020304);
    chk("bb_vo_req", 32'(valid_out), 32'd0);
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    chk("bb_done", 32'(valid_out), 32'd1);
    allow_out = 1'b1;
    @(negedge clk);
    allow_out = 1'b0;

    // flush while holding in DONE
    set_in(v[17]);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("fd_vo", 32'(valid_out), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fd_vo_clr", 32'(valid_out), 32'd0);
    chk("fd_allow_in", 32'(allow_in), 32'd1);

    // reset mid-transaction
    set_in(v[1]);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("mr_req", 32'(data_sram_req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mr_req_async", 32'(data_sram_req), 32'd0);
    chk("mr_addr_async", data_sram_addr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("mr_idle_req", 32'(data_sram_req), 32'd0);
    chk("mr_idle_allow", 32'(allow_in), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
